// File: rtl/sm_pkg.sv
// Shared types/constants for the register scanner.
// Define SM_REG_SCAN_SKIP_ZERO_EN to never address register $0 (reset/wrap address becomes 1).
package sm_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DWELL   = 2'd3
    } state_t;

`ifdef SM_REG_SCAN_SKIP_ZERO_EN
    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(0);
`endif
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(31);

    // Address step with wrap back to the first scanned register.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_LAST) ? ADDR_FIRST : a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/sm_reg_scan_if.sv
// Debug read port to the core register file plus the display capture outputs.
interface sm_reg_scan_if;
    import sm_pkg::*;

    logic [ADDR_W-1:0] regAddr;
    logic [DATA_W-1:0] regData;
    logic [ADDR_W-1:0] dispAddr;
    logic [DATA_W-1:0] dispData;
    logic              dispValid;

    modport master (
        output regAddr, dispAddr, dispData, dispValid,
        input  regData
    );

    modport slave (
        input  regAddr, dispAddr, dispData, dispValid,
        output regData
    );

endinterface

// File: rtl/sm_debounce.sv
// Push-button conditioning: two-flop synchronizer, stability debounce, rising-edge step pulse.
module sm_debounce #(
    parameter int unsigned DEB_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic step
);

    logic [1:0]       sync;
    logic             deb;
    logic [DEB_W-1:0] cnt;

    // Debounced level flips only after 2^DEB_W consecutive cycles of disagreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            deb  <= 1'b0;
            cnt  <= '0;
            step <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            step <= 1'b0;
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == '1) begin
                deb  <= sync[1];
                cnt  <= '0;
                step <= sync[1];
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end
    end

endmodule

// File: rtl/sm_reg_scan.sv
// Register-file display scanner: auto-scan or manual step, settle, capture, dwell.
// Address range depends on SM_REG_SCAN_SKIP_ZERO_EN (see sm_pkg).
module sm_reg_scan
    import sm_pkg::*;
#(
    parameter int unsigned DWELL  = 24'd5000000,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned DEB_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scanEn,
    input  logic          stepBtn,
    sm_reg_scan_if.master bus
);

    localparam int unsigned SET_W   = 4;
    localparam int unsigned DWELL_W = $clog2(DWELL + 1);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_q, addr_nxt;
    logic [SET_W-1:0]   settle_cnt, settle_nxt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
    logic               load_c;
    logic               step;

    sm_debounce #(.DEB_W(DEB_W)) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (stepBtn),
        .step (step)
    );

    assign bus.regAddr = addr_q;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state, counters and address; step events outside IDLE are dropped.
    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr_q;
        settle_nxt = settle_cnt;
        dwell_nxt  = dwell_cnt;
        load_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (step) begin
                    addr_nxt  = next_addr(addr_q);
                    state_nxt = ST_SETTLE;
                end else if (scanEn) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SET_W'(SETTLE - 1)) begin
                    settle_nxt = '0;
                    load_c     = 1'b1;
                    state_nxt  = ST_CAPTURE;
                end else begin
                    settle_nxt = settle_cnt + SET_W'(1);
                end
            end
            ST_CAPTURE: begin
                state_nxt = scanEn ? ST_DWELL : ST_IDLE;
            end
            ST_DWELL: begin
                if (!scanEn) begin
                    dwell_nxt = '0;
                    state_nxt = ST_IDLE;
                end else if (dwell_cnt == DWELL_W'(DWELL - 1)) begin
                    dwell_nxt = '0;
                    addr_nxt  = next_addr(addr_q);
                    state_nxt = ST_SETTLE;
                end else begin
                    dwell_nxt = dwell_cnt + DWELL_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Display registers load on entry to CAPTURE so dispValid spans exactly the CAPTURE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q        <= ADDR_FIRST;
            settle_cnt    <= '0;
            dwell_cnt     <= '0;
            bus.dispAddr  <= '0;
            bus.dispData  <= '0;
            bus.dispValid <= 1'b0;
        end else begin
            addr_q        <= addr_nxt;
            settle_cnt    <= settle_nxt;
            dwell_cnt     <= dwell_nxt;
            bus.dispValid <= load_c;
            if (load_c) begin
                bus.dispAddr <= addr_q;
                bus.dispData <= bus.regData;
            end
        end
    end

endmodule

// File: tb/tb_sm_reg_scan.sv
// Directed bench for sm_reg_scan: reset, auto-scan cadence and wrap, manual step, debounce, aborts.
module tb_sm_reg_scan;

    localparam int unsigned DWELL  = 8;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned DEB_W  = 2;
    localparam int unsigned PERIOD = DWELL + SETTLE + 1;
`ifdef SM_REG_SCAN_SKIP_ZERO_EN
    localparam logic [4:0] FIRST = 5'd1;
`else
    localparam logic [4:0] FIRST = 5'd0;
`endif

    typedef struct {
        logic       scan_en;
        logic [4:0] addr;
        int         gap;
    } scan_vec_t;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic scanEn  = 1'b0;
    logic stepBtn = 1'b0;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    sm_reg_scan_if bus();

    assign bus.regData = 32'hA000_0000 | {27'd0, bus.regAddr};

    sm_reg_scan #(.DWELL(DWELL), .SETTLE(SETTLE), .DEB_W(DEB_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .scanEn  (scanEn),
        .stepBtn (stepBtn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.dispValid) pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.dispValid && n < max_cyc);
        if (!bus.dispValid) begin
            checks++;
            failures++;
            $display("FAIL wait_valid timeout actual=%0d cycles required=dispValid", n);
        end
    endtask

    task automatic press(input int len);
        stepBtn = 1'b1;
        repeat (len) tick();
        stepBtn = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        scan_vec_t  vec[6];
        int         n;
        int         lag;
        int         p0;
        int         guard;
        logic [4:0] a;

        for (int i = 0; i < 3; i++) vec[i] = '{1'b1, FIRST + 5'(i + 1), PERIOD};
        vec[3] = '{1'b1, 5'd30, PERIOD};
        vec[4] = '{1'b1, 5'd31, PERIOD};
        vec[5] = '{1'b1, FIRST, PERIOD};

        // Reset held with scanEn high.
        rst = 1'b1; scanEn = 1'b1;
        repeat (3) tick();
        check("rst_regAddr", 32'(bus.regAddr), 32'(FIRST));
        check("rst_dispAddr", 32'(bus.dispAddr), 0);
        check("rst_dispData", bus.dispData, 0);
        check("rst_dispValid", 32'(bus.dispValid), 0);

        rst = 1'b0;
        wait_valid(20, n);
        check("first_gap", n, 3);
        check("first_addr", 32'(bus.dispAddr), 32'(FIRST));
        check("first_data", bus.dispData, 32'hA000_0000 | 32'(FIRST));

        // Auto-scan cadence, then fast-forward to 29 and watch the wrap.
        lag = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                guard = 0;
                while (bus.dispAddr != 5'd29 && guard < 40) begin
                    wait_valid(PERIOD + 2, n);
                    guard++;
                end
                check("ff_addr", 32'(bus.dispAddr), 29);
                lag = 0;
            end
            scanEn = vec[i].scan_en;
            wait_valid(PERIOD + 5, n);
            check($sformatf("scan%0d_gap", i), n + lag, vec[i].gap);
            check($sformatf("scan%0d_addr", i), 32'(bus.dispAddr), 32'(vec[i].addr));
            check($sformatf("scan%0d_data", i), bus.dispData, 32'hA000_0000 | 32'(vec[i].addr));
            tick();
            check($sformatf("scan%0d_pulse_width", i), 32'(bus.dispValid), 0);
            lag = 1;
        end

        // scanEn dropped mid-DWELL: back to IDLE, address held.
        repeat (2) tick();
        scanEn = 1'b0;
        p0 = pulses;
        repeat (20) tick();
        check("dwell_drop_pulses", pulses - p0, 0);
        check("dwell_drop_regAddr", 32'(bus.regAddr), 32'(FIRST));

        // One clean 8-cycle press advances exactly once.
        p0 = pulses;
        press(8);
        repeat (30) tick();
        check("press_pulses", pulses - p0, 1);
        check("press_regAddr", 32'(bus.regAddr), 32'(FIRST + 5'd1));
        check("press_dispAddr", 32'(bus.dispAddr), 32'(FIRST + 5'd1));
        check("press_dispData", bus.dispData, 32'hA000_0000 | 32'(FIRST + 5'd1));

        // 3-cycle glitch is filtered.
        p0 = pulses;
        press(3);
        repeat (20) tick();
        check("glitch_pulses", pulses - p0, 0);
        check("glitch_regAddr", 32'(bus.regAddr), 32'(FIRST + 5'd1));

        // Step event timed to land while SETTLE is running: dropped, not queued.
        a = FIRST + 5'd1;
        p0 = pulses;
        stepBtn = 1'b1;
        repeat (5) tick();
        scanEn = 1'b1;
        tick();
        scanEn = 1'b0;
        repeat (3) tick();
        stepBtn = 1'b0;
        repeat (20) tick();
        check("settle_press_pulses", pulses - p0, 1);
        check("settle_press_regAddr", 32'(bus.regAddr), 32'(a));
        check("settle_press_dispAddr", 32'(bus.dispAddr), 32'(a));

        p0 = pulses;
        press(8);
        repeat (30) tick();
        check("after_settle_pulses", pulses - p0, 1);
        check("after_settle_dispAddr", 32'(bus.dispAddr), 32'(a + 5'd1));

        // Scan, drop scanEn in DWELL, restart, then reset during SETTLE.
        scanEn = 1'b1;
        wait_valid(20, n);
        check("restart_gap", n, 3);
        check("restart_addr", 32'(bus.dispAddr), 32'(a + 5'd1));
        repeat (3) tick();
        scanEn = 1'b0;
        repeat (3) tick();
        scanEn = 1'b1;
        tick();
        rst = 1'b1;
        scanEn = 1'b0;
        p0 = pulses;
        repeat (2) tick();
        rst = 1'b0;
        repeat (15) tick();
        check("abort_pulses", pulses - p0, 0);
        check("abort_regAddr", 32'(bus.regAddr), 32'(FIRST));
        check("abort_dispAddr", 32'(bus.dispAddr), 0);
        check("abort_dispData", bus.dispData, 0);
        check("abort_dispValid", 32'(bus.dispValid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
